// File: rtl/jtag_tap_pkg.sv
// ---------------------------------------------------------------------------
// jtag_tap_pkg
// Shared definitions for the clk-sampled JTAG TAP controller:
//   - tap_state_e : 4-bit TAP state codes (IEEE 1149.1 state graph)
//   - dr_sel_e    : which data register the current instruction selects
//   - instruction constants (IDCODE, USER base; all-zeros/all-ones = BYPASS)
//   - tap_next()  : TAP state transition for a given tms value
// ---------------------------------------------------------------------------
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  // BYPASS is both the all-zeros and the all-ones code; every unused code
  // also falls back to BYPASS.
  localparam int unsigned INSTR_BYPASS    = 0;
  localparam int unsigned INSTR_IDCODE    = 1;
  localparam int unsigned INSTR_USER_BASE = 2;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TLR;
    case (s)
      TLR:    n = tms ? TLR    : RTI;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SH_DR;
      SH_DR:  n = tms ? EX1_DR : SH_DR;
      EX1_DR: n = tms ? UPD_DR : PAU_DR;
      PAU_DR: n = tms ? EX2_DR : PAU_DR;
      EX2_DR: n = tms ? UPD_DR : SH_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SH_IR;
      SH_IR:  n = tms ? EX1_IR : SH_IR;
      EX1_IR: n = tms ? UPD_IR : PAU_IR;
      PAU_IR: n = tms ? EX2_IR : PAU_IR;
      EX2_IR: n = tms ? UPD_IR : SH_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// ---------------------------------------------------------------------------
// jtag_edge_sync
// Brings the asynchronous JTAG pins into the clk domain and flags tck edges.
//   clk, rst_n     : system clock, async active-low reset
//   tck, tms, tdi  : raw JTAG pins
//   tck_rise/fall  : one-clk pulses on a synchronised tck edge
//   tms_s, tdi_s   : synchronised tms/tdi, aligned with the tck samples
// ---------------------------------------------------------------------------
module jtag_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  // bit 0 = tck, bit 1 = tms, bit 2 = tdi; all three share the same two
  // stages so tms/tdi line up with the tck sample that produced the edge.
  logic [2:0] raw;
  logic [2:0] s1_reg;
  logic [2:0] s2_reg;
  logic       tck_prev_reg;
  logic [1:0] warm_reg;
  logic       hist_ok;

  assign raw = {tdi, tms, tck};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg       <= '0;
      s2_reg       <= '0;
      tck_prev_reg <= 1'b0;
      warm_reg     <= '0;
    end else begin
      s1_reg       <= raw;
      s2_reg       <= s1_reg;
      tck_prev_reg <= s2_reg[0];
      if (warm_reg != 2'd3) warm_reg <= warm_reg + 2'd1;
    end
  end

  // The reset zeros are not real pin samples: edges are only trusted once
  // tck_prev_reg holds a genuine sample (three clks after reset release),
  // so a tck that is already high at release never counts as a rise.
  assign hist_ok  = (warm_reg == 2'd3);
  assign tck_rise = hist_ok &  s2_reg[0] & ~tck_prev_reg;
  assign tck_fall = hist_ok & ~s2_reg[0] &  tck_prev_reg;
  assign tms_s    = s2_reg[1];
  assign tdi_s    = s2_reg[2];

endmodule

// File: rtl/jtag_tap_param.sv
// ---------------------------------------------------------------------------
// jtag_tap_param
// IEEE 1149.1 TAP controller running entirely on clk, with IDCODE, BYPASS
// and NUM_USER user data registers of USER_W bits each.
//   clk, rst_n     : system clock, async active-low reset
//   tck, tms, tdi  : JTAG pins (asynchronous, oversampled by clk)
//   user_cap       : capture values, slice k -> USERk
//   user_upd       : update registers, slice k <- USERk
//   user_stb       : one-clk strobe per slice when its update register loads
//   tdo, tdo_oe    : serial out and its drive enable
//   state_o, ir_o  : current TAP state code and latched instruction
// ---------------------------------------------------------------------------
module jtag_tap_param
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          NUM_USER   = 2,
  parameter int          USER_W     = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5B
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tck,
  input  logic                         tms,
  input  logic                         tdi,
  input  logic [NUM_USER*USER_W-1:0]   user_cap,
  output logic [NUM_USER*USER_W-1:0]   user_upd,
  output logic [NUM_USER-1:0]          user_stb,
  output logic                         tdo,
  output logic                         tdo_oe,
  output logic [3:0]                   state_o,
  output logic [IR_WIDTH-1:0]          ir_o
);

  // One DR shifter serves every data register; its active length follows
  // the selected instruction (IDCODE is the widest at 32 bits).
  localparam int DR_W = 32;

  logic tck_rise;
  logic tck_fall;
  logic tms_s;
  logic tdi_s;

  tap_state_e state_reg;
  tap_state_e state_next;

  logic [IR_WIDTH-1:0] ir_sh_reg;
  logic [IR_WIDTH-1:0] ir_reg;
  logic [DR_W-1:0]     dr_sh_reg;
  logic [DR_W-1:0]     dr_shifted;
  logic [DR_W-1:0]     cap_val;
  logic [USER_W-1:0]   cap_user;
  dr_sel_e             dr_sel;
  logic [1:0]          user_idx;
  logic [5:0]          dr_len;
  logic                tdo_reg;
  logic                tdo_oe_reg;
  logic                upd_fire;

  jtag_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  // ---------------- TAP state machine ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= TLR;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (tck_rise) state_next = tap_next(state_reg, tms_s);
  end

  // ---------------- instruction decode ----------------
  always_comb begin
    dr_sel   = SEL_BYPASS;
    user_idx = '0;
    if (ir_reg == IR_WIDTH'(INSTR_IDCODE)) dr_sel = SEL_IDCODE;
    for (int k = 0; k < NUM_USER; k++) begin
      // all-ones stays BYPASS even when it collides with a USER code
      if (ir_reg == IR_WIDTH'(INSTR_USER_BASE + k) && ir_reg != '1) begin
        dr_sel   = SEL_USER;
        user_idx = 2'(k);
      end
    end
  end

  always_comb begin
    cap_user = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      if (user_idx == 2'(k)) cap_user = user_cap[k*USER_W +: USER_W];
    end
  end

  always_comb begin
    cap_val = '0;
    dr_len  = 6'd1;
    case (dr_sel)
      SEL_IDCODE: begin
        cap_val = IDCODE_VAL;
        dr_len  = 6'(DR_W);
      end
      SEL_USER: begin
        cap_val = DR_W'(cap_user);
        dr_len  = 6'(USER_W);
      end
      default: begin
        cap_val = '0;
        dr_len  = 6'd1;
      end
    endcase
  end

  // Right shift within the active length: tdi enters at bit dr_len-1 and
  // everything above the active length is kept at zero.
  generate
    for (genvar gi = 0; gi < DR_W; gi++) begin : g_dr_shift
      if (gi == DR_W - 1) begin : g_top
        assign dr_shifted[gi] = (dr_len == 6'(DR_W)) ? tdi_s : 1'b0;
      end else begin : g_mid
        assign dr_shifted[gi] = (dr_len == 6'(gi + 1)) ? tdi_s :
                                (6'(gi + 1) < dr_len)  ? dr_sh_reg[gi + 1] : 1'b0;
      end
    end
  endgenerate

  // ---------------- shifters (tck rise actions) ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_sh_reg <= '0;
      dr_sh_reg <= '0;
    end else if (state_reg == TLR) begin
      // an abort through TLR throws away anything half-shifted
      ir_sh_reg <= '0;
      dr_sh_reg <= '0;
    end else if (tck_rise) begin
      case (state_reg)
        CAP_IR:  ir_sh_reg <= IR_WIDTH'(1);
        SH_IR:   ir_sh_reg <= {tdi_s, ir_sh_reg[IR_WIDTH-1:1]};
        CAP_DR:  dr_sh_reg <= cap_val;
        SH_DR:   dr_sh_reg <= dr_shifted;
        default: ;
      endcase
    end
  end

  // ---------------- instruction register / tdo (tck fall actions) ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_reg <= IR_WIDTH'(INSTR_IDCODE);
    end else if (state_reg == TLR) begin
      ir_reg <= IR_WIDTH'(INSTR_IDCODE);
    end else if (tck_fall && state_reg == UPD_IR) begin
      ir_reg <= ir_sh_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo_reg    <= 1'b0;
      tdo_oe_reg <= 1'b0;
    end else if (tck_fall) begin
      case (state_reg)
        SH_IR: begin
          tdo_reg    <= ir_sh_reg[0];
          tdo_oe_reg <= 1'b1;
        end
        SH_DR: begin
          tdo_reg    <= dr_sh_reg[0];
          tdo_oe_reg <= 1'b1;
        end
        default: begin
          tdo_reg    <= 1'b0;
          tdo_oe_reg <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- user update registers ----------------
  assign upd_fire = tck_fall && (state_reg == UPD_DR) && (dr_sel == SEL_USER);

  generate
    for (genvar gi = 0; gi < NUM_USER; gi++) begin : g_user
      logic [USER_W-1:0] upd_reg;
      logic              stb_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          upd_reg <= '0;
          stb_reg <= 1'b0;
        end else begin
          stb_reg <= 1'b0;
          if (upd_fire && user_idx == 2'(gi)) begin
            upd_reg <= dr_sh_reg[USER_W-1:0];
            stb_reg <= 1'b1;
          end
        end
      end

      assign user_upd[gi*USER_W +: USER_W] = upd_reg;
      assign user_stb[gi]                  = stb_reg;
    end
  endgenerate

  assign state_o = state_reg;
  assign ir_o    = ir_reg;
  assign tdo     = tdo_reg;
  assign tdo_oe  = tdo_oe_reg;

endmodule

// File: tb/tb_jtag_tap_param.sv
// ---------------------------------------------------------------------------
// tb_jtag_tap_param
// Drives JTAG cycles (4 clk per tck phase), predicts each cycle's outcome
// with a state-graph / bit-vector model and queues it; a monitor pops and
// compares when the next tck rise is issued (or on an explicit flush).
// ---------------------------------------------------------------------------
module tb_jtag_tap_param;

  localparam int          IRW = 4;
  localparam int          NU  = 2;
  localparam int          UW  = 8;
  localparam logic [31:0] IDC = 32'h1000_0A5B;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              tck = 1'b0;
  logic              tms = 1'b0;
  logic              tdi = 1'b0;
  logic [NU*UW-1:0]  user_cap = '0;
  logic [NU*UW-1:0]  user_upd;
  logic [NU-1:0]     user_stb;
  logic              tdo;
  logic              tdo_oe;
  logic [3:0]        state_o;
  logic [IRW-1:0]    ir_o;

  always #5 clk = ~clk;

  jtag_tap_param #(
    .IR_WIDTH   (IRW),
    .NUM_USER   (NU),
    .USER_W     (UW),
    .IDCODE_VAL (IDC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .user_cap (user_cap),
    .user_upd (user_upd),
    .user_stb (user_stb),
    .tdo      (tdo),
    .tdo_oe   (tdo_oe),
    .state_o  (state_o),
    .ir_o     (ir_o)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // observed strobe-high clk counts per slice
  int stb_seen [NU];
  initial for (int k = 0; k < NU; k++) stb_seen[k] = 0;
  always @(negedge clk) begin
    for (int k = 0; k < NU; k++) if (user_stb[k] === 1'b1) stb_seen[k]++;
  end

  // ---------------- reference model ----------------
  // IEEE 1149.1 graph as lookup tables indexed by state code
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_st;
  logic [3:0]  m_ir;
  logic [3:0]  m_irsh;
  logic [31:0] m_dr;
  logic        m_tdo;
  logic        m_oe;
  logic [15:0] m_upd;
  int          m_stb [NU];

  typedef struct {
    int          st;
    logic [3:0]  ir;
    logic        tdo;
    logic        oe;
    logic [15:0] upd;
    int          s0;
    int          s1;
  } exp_t;
  exp_t q[$];

  function automatic int user_of(input logic [3:0] ir);
    if (ir >= 4'd2 && int'(ir) < 2 + NU && ir != 4'hF) return int'(ir) - 2;
    return -1;
  endfunction

  function automatic int dr_len_of(input logic [3:0] ir);
    if (ir == 4'd1) return 32;
    if (user_of(ir) >= 0) return UW;
    return 1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ir = 4'd1; m_irsh = '0; m_dr = '0;
    m_tdo = 1'b0; m_oe = 1'b0; m_upd = '0;
  endtask

  task automatic model_rise(input logic tms_v, input logic tdi_v);
    int len;
    int u;
    len = dr_len_of(m_ir);
    u   = user_of(m_ir);
    case (m_st)
      10: m_irsh = 4'b0001;
      11: m_irsh = {tdi_v, m_irsh[3:1]};
      3: begin
        if (m_ir == 4'd1)  m_dr = IDC;
        else if (u >= 0)   m_dr = 32'(user_cap[u*UW +: UW]);
        else               m_dr = '0;
      end
      4: begin
        m_dr = m_dr >> 1;
        m_dr[len-1] = tdi_v;
      end
      default: ;
    endcase
    m_st = tms_v ? nxt1[m_st] : nxt0[m_st];
    if (m_st == 0) begin
      m_ir = 4'd1; m_irsh = '0; m_dr = '0;
    end
  endtask

  task automatic model_fall();
    int u;
    exp_t e;
    u = user_of(m_ir);
    if (m_st == 11)      begin m_tdo = m_irsh[0]; m_oe = 1'b1; end
    else if (m_st == 4)  begin m_tdo = m_dr[0];   m_oe = 1'b1; end
    else                 begin m_tdo = 1'b0;      m_oe = 1'b0; end
    if (m_st == 15) m_ir = m_irsh;
    if (m_st == 8 && u >= 0) begin
      m_upd[u*UW +: UW] = m_dr[UW-1:0];
      m_stb[u]++;
    end
    e.st = m_st; e.ir = m_ir; e.tdo = m_tdo; e.oe = m_oe;
    e.upd = m_upd; e.s0 = m_stb[0]; e.s1 = m_stb[1];
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic        flush_req = 1'b0;
  logic [31:0] tdo_log = '0;   // tdo bits while driven, newest at bit 31

  initial begin
    exp_t e;
    forever begin
      @(posedge tck or posedge flush_req);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("state",  32'(state_o),  32'(e.st));
        check("ir",     32'(ir_o),     32'(e.ir));
        check("tdo",    32'(tdo),      32'(e.tdo));
        check("tdo_oe", 32'(tdo_oe),   32'(e.oe));
        check("upd",    32'(user_upd), 32'(e.upd));
        check("stb0",   32'(stb_seen[0]), 32'(e.s0));
        check("stb1",   32'(stb_seen[1]), 32'(e.s1));
        $display("txn st=%0d ir=%h tdo=%b oe=%b upd=%h", state_o, ir_o, tdo, tdo_oe, user_upd);
        if (tdo_oe === 1'b1) tdo_log = {tdo, tdo_log[31:1]};
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tck_cycle(input logic tms_v, input logic tdi_v);
    @(negedge clk);
    tms = tms_v; tdi = tdi_v; tck = 1'b1;
    model_rise(tms_v, tdi_v);
    repeat (4) @(negedge clk);
    tck = 1'b0;
    model_fall();
    repeat (4) @(negedge clk);
  endtask

  task automatic flush();
    flush_req = 1'b1;
    #2;
    flush_req = 1'b0;
    @(negedge clk);
  endtask

  // from RTI: load a 4-bit instruction, end in RTI
  task automatic load_ir(input logic [3:0] v);
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 4; i++) tck_cycle(i == 3, v[i]);
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  // from RTI: capture, shift n bits of data LSB-first, update, end in RTI
  task automatic shift_dr(input logic [31:0] data, input int n);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, data[i]);
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  // async reset pulse with immediate checks; tck is left high across the
  // release so a spurious rise would move the TAP out of TLR
  task automatic do_reset();
    flush();
    #3 rst_n = 1'b0;
    #1;
    check("rst_state",  32'(state_o),  32'd0);
    check("rst_ir",     32'(ir_o),     32'd1);
    check("rst_tdo",    32'(tdo),      32'd0);
    check("rst_tdo_oe", 32'(tdo_oe),   32'd0);
    check("rst_upd",    32'(user_upd), 32'd0);
    check("rst_stb",    32'(user_stb), 32'd0);
    model_reset();
    tck = 1'b1; tms = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
    check("no_false_rise", 32'(state_o), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base0;
    int base1;
    for (int k = 0; k < NU; k++) m_stb[k] = 0;
    model_reset();
    user_cap = 16'($urandom);
    do_reset();

    // IDCODE read straight out of reset
    tck_cycle(0, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 31; i++) tck_cycle(0, 1'($urandom));
    tck_cycle(1, 1'($urandom));
    flush();
    check("idcode_stream", tdo_log, IDC);
    tck_cycle(1, 0); tck_cycle(0, 0);

    // USER0 update
    base0 = stb_seen[0]; base1 = stb_seen[1];
    load_ir(4'h2);
    shift_dr(32'hA5, 8);
    flush();
    check("user0_upd",   32'(user_upd[7:0]),  32'hA5);
    check("user1_hold",  32'(user_upd[15:8]), 32'h00);
    check("stb0_pulse",  32'(stb_seen[0] - base0), 32'd1);
    check("stb1_quiet",  32'(stb_seen[1] - base1), 32'd0);

    // BYPASS one-bit delay
    load_ir(4'hF);
    shift_dr(32'b1101, 4);
    flush();
    check("bypass_delay", 32'(tdo_log[31:28]), 32'b1010);

    // USER1 capture
    user_cap[15:8] = 8'h3C;
    load_ir(4'h3);
    shift_dr(32'($urandom), 8);
    flush();
    check("user1_cap", 32'(tdo_log[31:24]), 32'h3C);

    // IR capture pattern, then abort from SH_DR
    load_ir(4'h1);
    flush();
    check("ir_capture", 32'(tdo_log[31:28]), 32'b0001);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    tck_cycle(0, 1); tck_cycle(0, 0);
    for (int i = 0; i < 5; i++) tck_cycle(1, 1'($urandom));
    flush();
    check("five_tms_tlr", 32'(state_o), 32'd0);

    // reset in the middle of SH_DR
    tck_cycle(0, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    tck_cycle(0, 1); tck_cycle(0, 1);
    flush();
    check("in_sh_dr", 32'(state_o), 32'd4);
    do_reset();

    // random walk
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) user_cap = 16'($urandom);
      tck_cycle($urandom_range(0, 3) == 0, 1'($urandom));
    end
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtag_tap_param.md
JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 SHALL provide parameter IR_WIDTH, default 4, instruction register width (range 2..8).
REQ-002 SHALL provide parameter NUM_USER, default 2, number of user data registers (range 1..4).
REQ-003 SHALL provide parameter USER_W, default 8, width of each user data register (range 1..32).
REQ-004 SHALL provide parameter IDCODE_VAL, default 32'h1000_0A5B, IDCODE register value; bit 0 SHALL be 1.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port tck  input  1  JTAG test clock, asynchronous, sampled by clk.
REQ-008 SHALL have port tms  input  1  JTAG mode select, asynchronous.
REQ-009 SHALL have port tdi  input  1  JTAG serial data in, asynchronous.
REQ-010 SHALL have port user_cap  input  NUM_USER*USER_W  capture values; slice k belongs to USERk.
REQ-011 SHALL have port user_upd  output  NUM_USER*USER_W  update registers; slice k belongs to USERk.
REQ-012 SHALL have port user_stb  output  NUM_USER  one-clk pulse per slice on update.
REQ-013 SHALL have port tdo  output  1  serial data out.
REQ-014 SHALL have port tdo_oe  output  1  tdo drive enable.
REQ-015 SHALL have port state_o  output  4  current TAP state code.
REQ-016 SHALL have port ir_o  output  IR_WIDTH  current latched instruction.

Function
REQ-017 tck, tms, tdi SHALL each pass a 2-flop synchroniser; tck rise/fall SHALL be detected from synchronised samples; tck high and low phases SHALL each be at least 3 clk.
REQ-018 TAP FSM SHALL implement the 16 IEEE 1149.1 states, advancing once per detected tck rise using the synchronised tms of that edge; state_o SHALL update on the clk after detection.
REQ-019 Five consecutive tck rises with tms=1 SHALL reach TLR from any state.
REQ-020 Instruction decode: all-zeros -> BYPASS, 1 -> IDCODE, 2+k (k < NUM_USER) -> USERk, all-ones -> BYPASS, any other code -> BYPASS.
REQ-021 Actions on tck rise while in a state: CAP_IR loads IR shifter with ...01 (LSBs 2'b01, upper bits 0); CAP_DR loads the selected DR (IDCODE_VAL, 1'b0 for BYPASS, user_cap slice for USERk); SH_IR/SH_DR shift right with tdi into the MSB.
REQ-022 Actions on tck fall: tdo SHALL take the LSB of the active shifter and tdo_oe SHALL be 1 if state is SH_IR or SH_DR, else tdo_oe=0 and tdo=0; in UPD_IR, ir_o SHALL latch the IR shifter; in UPD_DR with USERk selected, user_upd slice k SHALL latch the DR shifter and user_stb[k] SHALL pulse for exactly one clk.
REQ-023 In TLR, ir_o SHALL be forced to IDCODE (1) on every clk.
REQ-024 PAUSE and EXIT states SHALL hold shifter contents unchanged.
REQ-025 No update SHALL occur unless the UPD_IR/UPD_DR state is entered; aborting via TLR SHALL discard shifter contents.

Reset
REQ-026 rst_n low SHALL immediately set state_o=TLR (0), ir_o=1, tdo=0, tdo_oe=0, user_upd=0, user_stb=0, shifters=0, synchronisers=0.
REQ-027 After rst_n deasserts, the first tck rise SHALL NOT be detected until synchroniser history holds a low-then-high sample.

Structure
REQ-028 Package jtag_tap_pkg SHALL hold the 4-bit state typedef with codes TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PAU_DR=6, EX2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PAU_IR=13, EX2_IR=14, UPD_IR=15, plus the IDCODE/BYPASS/USER-base instruction constants.
REQ-029 Sub-module jtag_edge_sync SHALL contain the 2-flop synchronisers and tck rise/fall detection.

Verification
REQ-030 rst_n pulse mid-SH_DR -> state_o=0, ir_o=4'h1, tdo_oe=0 within the same clk edge.
REQ-031 From reset, TMS 0,1,0,0 then 32 shifts -> tdo stream LSB-first equals 32'h1000_0A5B.
REQ-032 Load IR=4'h2, shift 8'hA5 into DR, go to UPD_DR -> user_upd[7:0]=8'hA5, user_stb=2'b01 for one clk, user_upd[15:8] unchanged.
REQ-033 IR=4'hF, shift tdi 1,0,1,1 -> tdo shows 0,1,0,1 (one-bit delay).
REQ-034 In SH_IR read 4 bits -> tdo LSB-first 1,0,0,0; five tms=1 rises from SH_DR -> state_o=0.
REQ-035 user_cap[15:8]=8'h3C, IR=4'h3, capture and shift 8 -> tdo LSB-first 0,0,1,1,1,1,0,0.
